id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Registers decoded operands and control, and decodes ALUOp/funct into the 4-bit ALU control code.
- Selects ALU operands with EX/MEM and MEM/WB forwarding, and flags load-use hazards back to decode.
- Supports stall (hold) and flush (bubble).

Parameters:
- DATA_W, 32, operand/result width.
- RA_W, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold stage contents.
- i_flush  in  1  load bubble.
- i_valid  in  1  decode slot holds an instruction.
- i_rs_data, i_rt_data  in  DATA_W  register file read data.
- i_imm16  in  16  instruction immediate.
- i_zero_ext  in  1  1 = zero-extend imm, 0 = sign-extend.
- i_rs_addr, i_rt_addr, i_rd_addr  in  RA_W  register specifiers.
- i_alu_op  in  2  00 add, 01 sub, 10 R-type (funct), 11 or.
- i_funct  in  6  R-type function field.
- i_alu_src  in  1  1 = op2 is immediate.
- i_reg_dst  in  1  1 = dest is rd, 0 = dest is rt.
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1  control pass-through.
- i_exm_reg_write  in  1  EX/MEM write enable.
- i_exm_rd  in  RA_W  EX/MEM destination.
- i_exm_result  in  DATA_W  EX/MEM result.
- i_mwb_reg_write  in  1  MEM/WB write enable.
- i_mwb_rd  in  RA_W  MEM/WB destination.
- i_mwb_result  in  DATA_W  MEM/WB result.
- o_op1, o_op2  out  DATA_W  ALU operands.
- o_alu_control  out  4  ALU control code.
- o_store_data  out  DATA_W  forwarded rt value, for stores.
- o_dest  out  RA_W  write-back destination.
- o_valid  out  1  stage holds a live instruction.
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1  registered control.
- o_illegal  out  1  unsupported funct with alu_op=10.
- o_load_use  out  1  decode must stall.

Behaviour:
- Capture register updates on rising i_clk. Priority: i_rst > i_flush > i_stall > load.
- Reset and flush clear every register to 0: valid, control, data, addresses, and alu_control = 4'b0000.
- With forwarding inputs quiet, every output is 0 after reset.
- Stall: all registers hold. A flush in the same cycle wins and produces a bubble.
- Load:
  - Capture data and addresses.
  - dest = i_reg_dst ? rd : rt.
  - imm32 = zero- or sign-extended i_imm16.
  - Decoded alu_control is registered; decode is combinational from the same-cycle inputs.
  - If i_valid=0, all control bits load as 0.
- ALU control decode:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111.
  - alu_op 10, any other funct -> 0010 with illegal=1, registered.
  - o_illegal is gated by valid.
- Forwarding (combinational on registered addresses, same cycle as the ALU):
  - fwd_rs = exm match ? i_exm_result : mwb match ? i_mwb_result : r_rs_data.
  - Match = write enable & rd != 0 & rd == addr.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
  - fwd_rt is formed the same way.
- Outputs:
  - o_op1 = fwd_rs.
  - o_op2 = r_alu_src ? r_imm32 : fwd_rt.
  - o_store_data = fwd_rt.
- Latency: one cycle from decode inputs to registered outputs; zero cycles from forwarding inputs to operands.
- o_load_use (combinational) = r_valid & r_mem_read & r_dest != 0 & (r_dest == i_rs_addr | r_dest == i_rt_addr).
  - Decode responds with i_stall plus a next-cycle bubble.
  - Block does not self-stall.
- Mid-operation reset discards the held instruction at the next edge.

Decomposition:
- Shared package holds:
  - ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - ALUOp encodings.
  - funct constants.
- Sub-module alu_ctrl_dec: purely combinational, maps alu_op + funct to control and illegal. It is reused by the single-cycle datapath.
- Forwarding mux stays inline.

Test Plan:
- Reset held 2 cycles, forwarding inputs 0 -> all outputs 0, o_alu_control=0000. Release with valid add r3=r1+r2 (alu_op=10, funct=100000, rs=1 data 5, rt=2 data 7, rd=3, reg_dst=1) -> next cycle o_op1=5, o_op2=7, o_alu_control=0010, o_dest=3, o_valid=1.
- Captured rs=4 with exm (we=1, rd=4, result 0x11) and mwb (we=1, rd=4, result 0x22) -> o_op1=0x11. Drop exm we -> 0x22. Set rd=0 on both -> register value used.
- addi imm16=0xFFFE, zero_ext=0, alu_src=1 -> o_op2=0xFFFFFFFE. ori with zero_ext=1 -> o_op2=0x0000FFFE, control 0001.
- Captured lw dest=8 (mem_read=1), decode i_rt_addr=8 -> o_load_use=1. Same with dest=0 -> 0.
- Stall 3 cycles with changing inputs -> outputs frozen. Stall+flush same edge -> o_valid=0, all controls 0.
- funct 101010 -> 0111; funct 100111 -> 1100; funct 000011 with alu_op=10 -> 0010 and o_illegal=1.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage and the ALU control decoder:
// ALU control codes, ALUOp encodings and R-type funct values.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational ALUOp/funct to ALU control decoder, shared with the
// single-cycle datapath. Unknown R-type functs fall back to ADD and flag illegal.
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_illegal
);

  // Map ALUOp and funct onto the ALU control code
  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_OR:  o_alu_control = ALU_OR;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_alu_control = ALU_ADD;
          FUNCT_SUB: o_alu_control = ALU_SUB;
          FUNCT_AND: o_alu_control = ALU_AND;
          FUNCT_OR:  o_alu_control = ALU_OR;
          FUNCT_NOR: o_alu_control = ALU_NOR;
          FUNCT_SLT: o_alu_control = ALU_SLT;
          default: begin
            o_alu_control = ALU_ADD;
            o_illegal     = 1'b1;
          end
        endcase
      end
      default: begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// forwards EX/MEM and MEM/WB results into the operands and flags load-use hazards.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [15:0]       i_imm16,
  input  logic              i_zero_ext,
  input  logic [RA_W-1:0]   i_rs_addr,
  input  logic [RA_W-1:0]   i_rt_addr,
  input  logic [RA_W-1:0]   i_rd_addr,
  input  logic [1:0]        i_alu_op,
  input  logic [5:0]        i_funct,
  input  logic              i_alu_src,
  input  logic              i_reg_dst,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic              i_exm_reg_write,
  input  logic [RA_W-1:0]   i_exm_rd,
  input  logic [DATA_W-1:0] i_exm_result,
  input  logic              i_mwb_reg_write,
  input  logic [RA_W-1:0]   i_mwb_rd,
  input  logic [DATA_W-1:0] i_mwb_result,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [3:0]        o_alu_control,
  output logic [DATA_W-1:0] o_store_data,
  output logic [RA_W-1:0]   o_dest,
  output logic              o_valid,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg,
  output logic              o_illegal,
  output logic              o_load_use
);

  logic [3:0]        w_dec_ctrl;
  logic              w_dec_illegal;
  logic [DATA_W-1:0] w_imm_ext;
  logic [RA_W-1:0]   w_dest;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic              w_exm_rs_hit;
  logic              w_exm_rt_hit;
  logic              w_mwb_rs_hit;
  logic              w_mwb_rt_hit;

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_alu_src;
  logic              r_illegal;
  logic [3:0]        r_alu_control;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm32;
  logic [RA_W-1:0]   r_rs_addr;
  logic [RA_W-1:0]   r_rt_addr;
  logic [RA_W-1:0]   r_dest;

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_alu_op      (i_alu_op),
    .i_funct       (i_funct),
    .o_alu_control (w_dec_ctrl),
    .o_illegal     (w_dec_illegal)
  );

  assign w_imm_ext = i_zero_ext ? {{(DATA_W-16){1'b0}}, i_imm16}
                                : {{(DATA_W-16){i_imm16[15]}}, i_imm16};
  assign w_dest    = i_reg_dst ? i_rd_addr : i_rt_addr;

  // Pipeline register: reset/flush bubble, stall holds, otherwise capture decode
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src     <= 1'b0;
      r_illegal     <= 1'b0;
      r_alu_control <= 4'b0000;
      r_rs_data     <= {DATA_W{1'b0}};
      r_rt_data     <= {DATA_W{1'b0}};
      r_imm32       <= {DATA_W{1'b0}};
      r_rs_addr     <= {RA_W{1'b0}};
      r_rt_addr     <= {RA_W{1'b0}};
      r_dest        <= {RA_W{1'b0}};
    end else if (!i_stall) begin
      r_valid       <= i_valid;
      // An empty decode slot carries data but never any control
      r_reg_write   <= i_valid & i_reg_write;
      r_mem_read    <= i_valid & i_mem_read;
      r_mem_write   <= i_valid & i_mem_write;
      r_mem_to_reg  <= i_valid & i_mem_to_reg;
      r_alu_src     <= i_valid & i_alu_src;
      r_illegal     <= i_valid & w_dec_illegal;
      r_alu_control <= i_valid ? w_dec_ctrl : 4'b0000;
      r_rs_data     <= i_rs_data;
      r_rt_data     <= i_rt_data;
      r_imm32       <= w_imm_ext;
      r_rs_addr     <= i_rs_addr;
      r_rt_addr     <= i_rt_addr;
      r_dest        <= w_dest;
    end
  end

  assign w_exm_rs_hit = i_exm_reg_write && (i_exm_rd != {RA_W{1'b0}}) && (i_exm_rd == r_rs_addr);
  assign w_exm_rt_hit = i_exm_reg_write && (i_exm_rd != {RA_W{1'b0}}) && (i_exm_rd == r_rt_addr);
  assign w_mwb_rs_hit = i_mwb_reg_write && (i_mwb_rd != {RA_W{1'b0}}) && (i_mwb_rd == r_rs_addr);
  assign w_mwb_rt_hit = i_mwb_reg_write && (i_mwb_rd != {RA_W{1'b0}}) && (i_mwb_rd == r_rt_addr);

  // Operand forwarding, EX/MEM is the younger result and wins
  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
    if (w_exm_rs_hit) begin
      w_fwd_rs = i_exm_result;
    end else if (w_mwb_rs_hit) begin
      w_fwd_rs = i_mwb_result;
    end else begin
      w_fwd_rs = r_rs_data;
    end
    if (w_exm_rt_hit) begin
      w_fwd_rt = i_exm_result;
    end else if (w_mwb_rt_hit) begin
      w_fwd_rt = i_mwb_result;
    end else begin
      w_fwd_rt = r_rt_data;
    end
  end

  assign o_op1         = w_fwd_rs;
  assign o_op2         = r_alu_src ? r_imm32 : w_fwd_rt;
  assign o_store_data  = w_fwd_rt;
  assign o_alu_control = r_alu_control;
  assign o_dest        = r_dest;
  assign o_valid       = r_valid;
  assign o_reg_write   = r_reg_write;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_to_reg  = r_mem_to_reg;
  assign o_illegal     = r_valid & r_illegal;
  assign o_load_use    = r_valid && r_mem_read && (r_dest != {RA_W{1'b0}}) &&
                         ((r_dest == i_rs_addr) || (r_dest == i_rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed sequences, a decode table and
// randomized traffic against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        i_clk, i_rst, i_stall, i_flush, i_valid;
  logic [31:0] i_rs_data, i_rt_data;
  logic [15:0] i_imm16;
  logic        i_zero_ext;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic [1:0]  i_alu_op;
  logic [5:0]  i_funct;
  logic        i_alu_src, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic        i_exm_reg_write, i_mwb_reg_write;
  logic [4:0]  i_exm_rd, i_mwb_rd;
  logic [31:0] i_exm_result, i_mwb_result;
  logic [31:0] o_op1, o_op2, o_store_data;
  logic [3:0]  o_alu_control;
  logic [4:0]  o_dest;
  logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_illegal, o_load_use;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm16(i_imm16), .i_zero_ext(i_zero_ext),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
    .i_alu_op(i_alu_op), .i_funct(i_funct), .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg),
    .i_exm_reg_write(i_exm_reg_write), .i_exm_rd(i_exm_rd), .i_exm_result(i_exm_result),
    .i_mwb_reg_write(i_mwb_reg_write), .i_mwb_rd(i_mwb_rd), .i_mwb_result(i_mwb_result),
    .o_op1(o_op1), .o_op2(o_op2), .o_alu_control(o_alu_control), .o_store_data(o_store_data),
    .o_dest(o_dest), .o_valid(o_valid), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_illegal(o_illegal),
    .o_load_use(o_load_use)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic       ill;
  } dvec_t;

  // What the stage should be holding, in instruction terms
  typedef struct {
    logic        valid, rw, mr, mw, m2r, imm_sel, ill;
    logic [3:0]  ctrl;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  rs, rt, dest;
  } held_t;

  held_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_rs_data = 32'd0; i_rt_data = 32'd0; i_imm16 = 16'd0; i_zero_ext = 1'b0;
    i_rs_addr = 5'd0; i_rt_addr = 5'd0; i_rd_addr = 5'd0;
    i_alu_op = 2'b00; i_funct = 6'd0; i_alu_src = 1'b0; i_reg_dst = 1'b0;
    i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
    i_exm_reg_write = 1'b0; i_exm_rd = 5'd0; i_exm_result = 32'd0;
    i_mwb_reg_write = 1'b0; i_mwb_rd = 5'd0; i_mwb_result = 32'd0;
  endtask

  // {illegal, control} from the ALU control table
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] funct);
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (op == 2'b11) return {1'b0, 4'b0001};
    case (funct)
      6'b100000: return {1'b0, 4'b0010};
      6'b100010: return {1'b0, 4'b0110};
      6'b100100: return {1'b0, 4'b0000};
      6'b100101: return {1'b0, 4'b0001};
      6'b100111: return {1'b0, 4'b1100};
      6'b101010: return {1'b0, 4'b0111};
      default:   return {1'b1, 4'b0010};
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] regval);
    if (i_exm_reg_write && i_exm_rd != 5'd0 && i_exm_rd == a) return i_exm_result;
    if (i_mwb_reg_write && i_mwb_rd != 5'd0 && i_mwb_rd == a) return i_mwb_result;
    return regval;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [4:0] d;
    if (i_rst || i_flush) begin
      m = '{default: '0};
    end else if (!i_stall) begin
      d         = ref_dec(i_alu_op, i_funct);
      m.valid   = i_valid;
      m.rw      = i_valid && i_reg_write;
      m.mr      = i_valid && i_mem_read;
      m.mw      = i_valid && i_mem_write;
      m.m2r     = i_valid && i_mem_to_reg;
      m.imm_sel = i_valid && i_alu_src;
      m.ill     = i_valid && d[4];
      m.ctrl    = i_valid ? d[3:0] : 4'b0000;
      m.rs_val  = i_rs_data;
      m.rt_val  = i_rt_data;
      m.imm     = i_zero_ext ? {16'h0000, i_imm16} : {{16{i_imm16[15]}}, i_imm16};
      m.rs      = i_rs_addr;
      m.rt      = i_rt_addr;
      m.dest    = i_reg_dst ? i_rd_addr : i_rt_addr;
    end
  endtask

  task automatic check_model();
    logic [31:0] rt_f;
    logic        lu;
    rt_f = ref_fwd(m.rt, m.rt_val);
    lu   = m.valid && m.mr && m.dest != 5'd0 && (m.dest == i_rs_addr || m.dest == i_rt_addr);
    chk("rnd_op1", o_op1, ref_fwd(m.rs, m.rs_val));
    chk("rnd_store", o_store_data, rt_f);
    chk("rnd_dest", {27'd0, o_dest}, {27'd0, m.dest});
    chk("rnd_valid", {31'd0, o_valid}, {31'd0, m.valid});
    chk("rnd_ctl", {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg},
        {28'd0, m.rw, m.mr, m.mw, m.m2r});
    chk("rnd_illegal", {31'd0, o_illegal}, {31'd0, m.ill});
    chk("rnd_load_use", {31'd0, o_load_use}, {31'd0, lu});
    if (m.valid) begin
      chk("rnd_op2", o_op2, m.imm_sel ? m.imm : rt_f);
      chk("rnd_alu_ctrl", {28'd0, o_alu_control}, {28'd0, m.ctrl});
    end
  endtask

  dvec_t tbl[12];
  logic [5:0] functs[8];

  initial begin
    tbl[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    tbl[1]  = '{2'b01, 6'b100100, 4'b0110, 1'b0};
    tbl[2]  = '{2'b11, 6'b000011, 4'b0001, 1'b0};
    tbl[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    tbl[4]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    tbl[5]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    tbl[6]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    tbl[7]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    tbl[8]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    tbl[9]  = '{2'b10, 6'b000011, 4'b0010, 1'b1};
    tbl[10] = '{2'b10, 6'b111111, 4'b0010, 1'b1};
    tbl[11] = '{2'b10, 6'b100001, 4'b0010, 1'b1};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b100111, 6'b101010, 6'b000011, 6'b110011};

    // Reset for two cycles with forwarding quiet
    clear_inputs();
    i_rst = 1'b1;
    tick(); tick();
    chk("rst_op1", o_op1, 32'd0);
    chk("rst_op2", o_op2, 32'd0);
    chk("rst_store", o_store_data, 32'd0);
    chk("rst_alu_ctrl", {28'd0, o_alu_control}, 32'd0);
    chk("rst_misc", {24'd0, o_dest, o_valid, o_illegal, o_load_use},  32'd0);
    chk("rst_ctl", {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}, 32'd0);

    // add r3 = r1 + r2
    i_rst = 1'b0; i_valid = 1'b1; i_alu_op = 2'b10; i_funct = 6'b100000;
    i_rs_addr = 5'd1; i_rs_data = 32'd5; i_rt_addr = 5'd2; i_rt_data = 32'd7;
    i_rd_addr = 5'd3; i_reg_dst = 1'b1; i_reg_write = 1'b1;
    tick();
    chk("add_op1", o_op1, 32'd5);
    chk("add_op2", o_op2, 32'd7);
    chk("add_ctrl", {28'd0, o_alu_control}, 32'h2);
    chk("add_dest", {27'd0, o_dest}, 32'd3);
    chk("add_valid", {31'd0, o_valid}, 32'd1);

    // Stall three cycles while decode inputs change
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_rs_data = $urandom; i_rt_data = $urandom; i_rd_addr = 5'd9 + 5'(k);
      i_funct = 6'b100010; i_alu_op = 2'b01; i_valid = k[0];
      tick();
      chk("stall_op1", o_op1, 32'd5);
      chk("stall_op2", o_op2, 32'd7);
      chk("stall_ctrl_dest", {23'd0, o_alu_control, o_dest}, {23'd0, 4'b0010, 5'd3});
      chk("stall_valid", {30'd0, o_valid, o_reg_write}, 32'd3);
    end
    i_flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_ctl", {23'd0, o_alu_control, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_illegal}, 32'd0);
    chk("flush_op1", o_op1, 32'd0);

    // Forwarding priority on rs and rt
    clear_inputs();
    i_valid = 1'b1; i_rs_addr = 5'd4; i_rs_data = 32'h99; i_rt_addr = 5'd6; i_rt_data = 32'h77;
    i_rd_addr = 5'd7; i_reg_dst = 1'b1; i_alu_op = 2'b10; i_funct = 6'b100000;
    tick();
    i_stall = 1'b1;
    i_exm_reg_write = 1'b1; i_exm_rd = 5'd4; i_exm_result = 32'h11;
    i_mwb_reg_write = 1'b1; i_mwb_rd = 5'd4; i_mwb_result = 32'h22;
    #1 chk("fwd_exm", o_op1, 32'h11);
    i_exm_reg_write = 1'b0;
    #1 chk("fwd_mwb", o_op1, 32'h22);
    i_exm_reg_write = 1'b1; i_exm_rd = 5'd0; i_mwb_rd = 5'd0;
    #1 chk("fwd_r0", o_op1, 32'h99);
    i_mwb_rd = 5'd6;
    #1 chk("fwd_rt_op2", o_op2, 32'h22);
    chk("fwd_rt_store", o_store_data, 32'h22);
    chk("fwd_rt_op1", o_op1, 32'h99);

    // Immediates: sign-extended addi, zero-extended ori
    clear_inputs();
    i_valid = 1'b1; i_imm16 = 16'hFFFE; i_alu_src = 1'b1; i_alu_op = 2'b00; i_rt_data = 32'h5;
    tick();
    chk("addi_op2", o_op2, 32'hFFFF_FFFE);
    chk("addi_ctrl", {28'd0, o_alu_control}, 32'h2);
    chk("addi_store", o_store_data, 32'h5);
    i_zero_ext = 1'b1; i_alu_op = 2'b11;
    tick();
    chk("ori_op2", o_op2, 32'h0000_FFFE);
    chk("ori_ctrl", {28'd0, o_alu_control}, 32'h1);

    // Load-use hazard detection
    clear_inputs();
    i_valid = 1'b1; i_mem_read = 1'b1; i_reg_write = 1'b1; i_mem_to_reg = 1'b1;
    i_rt_addr = 5'd8; i_reg_dst = 1'b0;
    tick();
    i_valid = 1'b0; i_mem_read = 1'b0;
    chk("lw_dest", {27'd0, o_dest}, 32'd8);
    chk("lu_rt", {31'd0, o_load_use}, 32'd1);
    i_stall = 1'b1;
    i_rt_addr = 5'd9; i_rs_addr = 5'd8;
    #1 chk("lu_rs", {31'd0, o_load_use}, 32'd1);
    i_rs_addr = 5'd10;
    #1 chk("lu_none", {31'd0, o_load_use}, 32'd0);
    i_stall = 1'b0; i_valid = 1'b1; i_mem_read = 1'b1; i_rt_addr = 5'd0; i_rs_addr = 5'd0;
    tick();
    chk("lu_r0", {31'd0, o_load_use}, 32'd0);

    // ALU control decode table
    clear_inputs();
    i_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_alu_op = tbl[k].op; i_funct = tbl[k].funct;
      tick();
      chk($sformatf("dec%0d_ctrl", k), {28'd0, o_alu_control}, {28'd0, tbl[k].ctrl});
      chk($sformatf("dec%0d_ill", k), {31'd0, o_illegal}, {31'd0, tbl[k].ill});
    end

    // Invalid slot: illegal decode must not show
    i_valid = 1'b0; i_alu_op = 2'b10; i_funct = 6'b000011; i_reg_write = 1'b1;
    tick();
    chk("inv_gate", {29'd0, o_valid, o_illegal, o_reg_write}, 32'd0);

    // Mid-operation reset discards the held instruction
    i_valid = 1'b1; i_rs_data = 32'h1234; i_funct = 6'b100000;
    tick();
    chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_op1", o_op1, 32'd0);

    // Randomized traffic against the model
    m = '{default: '0};
    for (int n = 0; n < 400; n++) begin
      i_rst        = (n == 0) || ($urandom_range(0, 49) == 0);
      i_flush      = ($urandom_range(0, 9) == 0);
      i_stall      = ($urandom_range(0, 5) == 0);
      i_valid      = ($urandom_range(0, 3) != 0);
      i_rs_data    = $urandom; i_rt_data = $urandom;
      i_imm16      = 16'($urandom); i_zero_ext = 1'($urandom);
      i_rs_addr    = 5'($urandom_range(0, 7)); i_rt_addr = 5'($urandom_range(0, 7));
      i_rd_addr    = 5'($urandom_range(0, 7));
      i_alu_op     = 2'($urandom); i_funct = functs[$urandom_range(0, 7)];
      i_alu_src    = 1'($urandom); i_reg_dst = 1'($urandom);
      i_reg_write  = 1'($urandom); i_mem_read = 1'($urandom);
      i_mem_write  = 1'($urandom); i_mem_to_reg = 1'($urandom);
      i_exm_reg_write = 1'($urandom); i_exm_rd = 5'($urandom_range(0, 7)); i_exm_result = $urandom;
      i_mwb_reg_write = 1'($urandom); i_mwb_rd = 5'($urandom_range(0, 7)); i_mwb_result = $urandom;
      model_edge();
      tick();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
